// File: rtl/seq_ripple_adder_if.sv
// Operand/result bundle for seq_ripple_adder: request side driven by the
// producer, status and result side driven by the adder.
interface seq_ripple_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             ovf;

  modport master (
    output start, A, B, Cin, sub,
    input  busy, done, S, Cout, ovf
  );

  modport slave (
    input  start, A, B, Cin, sub,
    output busy, done, S, Cout, ovf
  );
endinterface

// File: rtl/seq_ripple_adder.sv
// Multi-cycle add/subtract: the ripple-carry chain is folded in time and
// evaluated DIGIT bits per clock, finishing with a one-cycle done pulse.
module seq_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  seq_ripple_adder_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   slice_sum;
  logic [WIDTH-1:0] slice_ext;
  logic [WIDTH-1:0] res_shift;
  logic             c_msb;

  // One slice of the chain; the carry into the slice's top bit is recovered
  // from its sum bit, which on the last slice is the carry into the word MSB.
  always_comb begin
    slice_sum = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};
    slice_ext = WIDTH'(slice_sum[DIGIT-1:0]);
    res_shift = (res_q >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
    c_msb     = slice_sum[DIGIT-1] ^ opa_q[DIGIT-1] ^ opb_q[DIGIT-1];
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1 with the borrow-in folded into the carry.
          state_d = RUN;
          count_d = '0;
          opa_d   = bus.A;
          opb_d   = bus.sub ? ~bus.B : bus.B;
          carry_d = bus.sub ? ~bus.Cin : bus.Cin;
          res_d   = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        res_d   = res_shift;
        carry_d = slice_sum[DIGIT];
        count_d = count_q + 1'b1;
        if (count_q == CW'(NDIG - 1)) begin
          state_d = DONE;
          s_d     = res_shift;
          cout_d  = slice_sum[DIGIT];
          ovf_d   = c_msb ^ slice_sum[DIGIT];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_ripple_adder.sv
// Bench for seq_ripple_adder: directed cases on a 16/4 instance, then a
// randomized sweep over five WIDTH/DIGIT configurations against an arithmetic model.
module tb_seq_ripple_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  start_s = '0;
  logic [31:0] a_s = '0;
  logic [31:0] b_s = '0;
  logic        cin_s = 1'b0;
  logic        sub_s = 1'b0;

  logic [4:0]  done_v, busy_v, cout_v, ovf_v;
  logic [31:0] s_v [5];

  int w_tab [5];
  int d_tab [5];
  int checks = 0;
  int failures = 0;

  seq_ripple_adder_if #(.WIDTH(16)) if0 ();
  seq_ripple_adder_if #(.WIDTH(16)) if1 ();
  seq_ripple_adder_if #(.WIDTH(16)) if2 ();
  seq_ripple_adder_if #(.WIDTH(32)) if3 ();
  seq_ripple_adder_if #(.WIDTH(12)) if4 ();

  seq_ripple_adder #(.WIDTH(16), .DIGIT(4))  dut0 (.clk(clk), .rst(rst), .bus(if0));
  seq_ripple_adder #(.WIDTH(16), .DIGIT(1))  dut1 (.clk(clk), .rst(rst), .bus(if1));
  seq_ripple_adder #(.WIDTH(16), .DIGIT(16)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  seq_ripple_adder #(.WIDTH(32), .DIGIT(8))  dut3 (.clk(clk), .rst(rst), .bus(if3));
  seq_ripple_adder #(.WIDTH(12), .DIGIT(4))  dut4 (.clk(clk), .rst(rst), .bus(if4));

  assign if0.start = start_s[0];
  assign if0.A = a_s[15:0];
  assign if0.B = b_s[15:0];
  assign if0.Cin = cin_s;
  assign if0.sub = sub_s;
  assign if1.start = start_s[1];
  assign if1.A = a_s[15:0];
  assign if1.B = b_s[15:0];
  assign if1.Cin = cin_s;
  assign if1.sub = sub_s;
  assign if2.start = start_s[2];
  assign if2.A = a_s[15:0];
  assign if2.B = b_s[15:0];
  assign if2.Cin = cin_s;
  assign if2.sub = sub_s;
  assign if3.start = start_s[3];
  assign if3.A = a_s;
  assign if3.B = b_s;
  assign if3.Cin = cin_s;
  assign if3.sub = sub_s;
  assign if4.start = start_s[4];
  assign if4.A = a_s[11:0];
  assign if4.B = b_s[11:0];
  assign if4.Cin = cin_s;
  assign if4.sub = sub_s;

  assign done_v = {if4.done, if3.done, if2.done, if1.done, if0.done};
  assign busy_v = {if4.busy, if3.busy, if2.busy, if1.busy, if0.busy};
  assign cout_v = {if4.Cout, if3.Cout, if2.Cout, if1.Cout, if0.Cout};
  assign ovf_v  = {if4.ovf, if3.ovf, if2.ovf, if1.ovf, if0.ovf};
  assign s_v[0] = 32'(if0.S);
  assign s_v[1] = 32'(if1.S);
  assign s_v[2] = 32'(if2.S);
  assign s_v[3] = if3.S;
  assign s_v[4] = 32'(if4.S);

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Plain integer arithmetic: unsigned range for carry/borrow, signed range for overflow.
  function automatic void refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub,
                                   output logic [31:0] s, output logic cout, output logic ovf);
    longint span, ua, ub, ci, sa, sb, u, sv;
    span = longint'(1) << w;
    ua = longint'({32'd0, a}) & (span - 1);
    ub = longint'({32'd0, b}) & (span - 1);
    ci = cin ? 1 : 0;
    sa = (ua >= span / 2) ? ua - span : ua;
    sb = (ub >= span / 2) ? ub - span : ub;
    if (!sub) begin
      u = ua + ub + ci;
      sv = sa + sb + ci;
      cout = (u >= span);
    end else begin
      u = ua - ub - ci;
      sv = sa - sb - ci;
      cout = (u >= 0);
    end
    s = 32'(u & (span - 1));
    ovf = (sv >= span / 2) || (sv < -(span / 2));
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Start is held for one cycle, then operands are scrambled to prove they were captured.
  task automatic applyStimulus(input logic [4:0] mask, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic sub);
    start_s = mask;
    a_s = a;
    b_s = b;
    cin_s = cin;
    sub_s = sub;
    stepCycle();
    start_s = '0;
    a_s = $urandom;
    b_s = $urandom;
    cin_s = 1'($urandom_range(0, 1));
    sub_s = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDone(input int idx, input int lat0, input int budget, output int lat, output int busy_cnt);
    lat = lat0;
    busy_cnt = 0;
    while (done_v[idx] !== 1'b1 && lat < budget) begin
      if (busy_v[idx] === 1'b1) busy_cnt++;
      stepCycle();
      lat++;
    end
  endtask

  task automatic countDones(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (done_v[0] === 1'b1) cnt++;
      stepCycle();
    end
  endtask

  task automatic runDirected(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic sub,
                             input logic [31:0] es, input logic ec, input logic eo);
    int lat, bc;
    applyStimulus(5'b00001, a, b, cin, sub);
    waitDone(0, 1, 20, lat, bc);
    checkOutput({tag, " latency"}, 64'(lat), 64'd5);
    checkOutput({tag, " busy cycles"}, 64'(bc), 64'd4);
    checkOutput({tag, " S"}, 64'(s_v[0]), 64'(es));
    checkOutput({tag, " Cout"}, 64'(cout_v[0]), 64'(ec));
    checkOutput({tag, " ovf"}, 64'(ovf_v[0]), 64'(eo));
    stepCycle();
    checkOutput({tag, " done pulse width"}, 64'(done_v[0]), 64'd0);
    checkOutput({tag, " S held"}, 64'(s_v[0]), 64'(es));
  endtask

  initial begin
    int lat, bc, cnt, cyc;
    logic [31:0] ra, rb;
    logic rcin, rsub;
    logic [31:0] es [5];
    logic ec [5];
    logic eo [5];
    logic [4:0] seen;

    w_tab = '{16, 16, 16, 32, 12};
    d_tab = '{4, 1, 16, 8, 4};

    $display("[TB] reset");
    rst = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("reset busy", 64'(busy_v), 64'd0);
    checkOutput("reset done", 64'(done_v), 64'd0);
    checkOutput("reset S", 64'(s_v[0]), 64'd0);
    checkOutput("reset Cout", 64'(cout_v), 64'd0);
    checkOutput("reset ovf", 64'(ovf_v), 64'd0);
    rst = 1'b0;
    stepCycle();

    $display("[TB] directed cases");
    runDirected("add 1234+4321", 32'h1234, 32'h4321, 1'b0, 1'b0, 32'h5555, 1'b0, 1'b0);
    runDirected("ripple FFFF+1", 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0);
    runDirected("ripple FFFF+0+cin", 32'hFFFF, 32'h0000, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0);
    runDirected("ovf 7FFF+1", 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1);
    runDirected("ovf 8000+8000", 32'h8000, 32'h8000, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b1);
    runDirected("sub 5-7", 32'h0005, 32'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0);
    runDirected("sub 7-5-1", 32'h0007, 32'h0005, 1'b1, 1'b1, 32'h0001, 1'b1, 1'b0);
    runDirected("sub 8000-1", 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1);

    $display("[TB] start during RUN");
    applyStimulus(5'b00001, 32'h1111, 32'h2222, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(5'b00001, 32'hAAAA, 32'h5555, 1'b1, 1'b1);
    waitDone(0, 3, 20, lat, bc);
    checkOutput("run-start latency", 64'(lat), 64'd5);
    checkOutput("run-start S", 64'(s_v[0]), 64'h3333);
    stepCycle();
    countDones(8, cnt);
    checkOutput("run-start no queued op", 64'(cnt), 64'd0);

    $display("[TB] start in DONE");
    applyStimulus(5'b00001, 32'h0100, 32'h0200, 1'b0, 1'b0);
    waitDone(0, 1, 20, lat, bc);
    checkOutput("b2b first S", 64'(s_v[0]), 64'h0300);
    applyStimulus(5'b00001, 32'h1000, 32'h0001, 1'b0, 1'b1);
    waitDone(0, 1, 20, lat, bc);
    checkOutput("b2b second latency", 64'(lat), 64'd5);
    checkOutput("b2b second S", 64'(s_v[0]), 64'h0FFF);
    checkOutput("b2b second Cout", 64'(cout_v[0]), 64'd1);
    stepCycle();

    $display("[TB] reset mid-run");
    applyStimulus(5'b00001, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
    stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("abort busy", 64'(busy_v[0]), 64'd0);
    checkOutput("abort done", 64'(done_v[0]), 64'd0);
    checkOutput("abort S", 64'(s_v[0]), 64'd0);
    checkOutput("abort Cout", 64'(cout_v[0]), 64'd0);
    checkOutput("abort ovf", 64'(ovf_v[0]), 64'd0);
    countDones(8, cnt);
    checkOutput("abort no done", 64'(cnt), 64'd0);

    $display("[TB] random sweep");
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rcin = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      for (int i = 0; i < 5; i++) refModel(w_tab[i], ra, rb, rcin, rsub, es[i], ec[i], eo[i]);
      seen = '0;
      applyStimulus(5'b11111, ra, rb, rcin, rsub);
      cyc = 1;
      checkOutput("sweep busy", 64'(busy_v), 64'h1F);
      while (seen != 5'b11111 && cyc < 40) begin
        for (int i = 0; i < 5; i++) begin
          if (!seen[i] && done_v[i] === 1'b1) begin
            seen[i] = 1'b1;
            checkOutput($sformatf("sweep w%0d/d%0d latency", w_tab[i], d_tab[i]),
                        64'(cyc), 64'(w_tab[i] / d_tab[i] + 1));
            checkOutput($sformatf("sweep w%0d/d%0d S", w_tab[i], d_tab[i]), 64'(s_v[i]), 64'(es[i]));
            checkOutput($sformatf("sweep w%0d/d%0d Cout", w_tab[i], d_tab[i]), 64'(cout_v[i]), 64'(ec[i]));
            checkOutput($sformatf("sweep w%0d/d%0d ovf", w_tab[i], d_tab[i]), 64'(ovf_v[i]), 64'(eo[i]));
          end
        end
        if (seen != 5'b11111) begin
          stepCycle();
          cyc++;
        end
      end
      for (int i = 0; i < 5; i++)
        if (!seen[i]) checkOutput($sformatf("sweep w%0d/d%0d done timeout", w_tab[i], d_tab[i]), 64'd0, 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
